// File: rtl/alu_mdu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_mdu_pipe_if
//   Bundle of the EX-stage ALU/MDU handshake and data signals.
//
//   Signals (driver -> block):
//     in_valid   EX has a valid op this cycle
//     flush      abort any in-flight op (mispredict / trap)
//     ALUOp      4-bit operation select
//     A, B       ID/EX rs1 / rs2 values
//     Out        MEM/WB writeback value (forward source)
//     EM_Result  EX/MEM result (forward source)
//     Forward_A  operand A forward select
//     Forward_B  operand B forward select
//     ALUSrc     1 = use IDEX_Imm as operand B
//     IDEX_Imm   sign-extended immediate
//   Signals (block -> driver):
//     in_ready   block can accept an op (idle)
//     Result     registered result
//     Zero       registered (Result == 0)
//     out_valid  one-cycle pulse: Result/Zero updated this cycle
//     busy       multi-cycle op in progress (stall request)
//
//   Modports: master = EX/hazard side, slave = alu_mdu_pipe.
// -----------------------------------------------------------------------------
interface alu_mdu_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] EM_Result;
  logic [1:0]       Forward_A;
  logic [1:0]       Forward_B;
  logic             ALUSrc;
  logic [WIDTH-1:0] IDEX_Imm;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, flush, ALUOp, A, B, Out, EM_Result,
           Forward_A, Forward_B, ALUSrc, IDEX_Imm,
    input  in_ready, Result, Zero, out_valid, busy
  );

  modport slave (
    input  in_valid, flush, ALUOp, A, B, Out, EM_Result,
           Forward_A, Forward_B, ALUSrc, IDEX_Imm,
    output in_ready, Result, Zero, out_valid, busy
  );
endinterface

// File: rtl/alu_mdu_pipe.sv
// -----------------------------------------------------------------------------
// alu_mdu_pipe
//   EX-stage ALU with operand forwarding plus an iterative multiply / unsigned
//   divide unit. Single-cycle ops complete at the accepting edge; MUL, MULHU,
//   DIVU and REMU take WIDTH cycles (one bit per cycle) and raise busy so the
//   hazard unit can freeze IF/ID/EX meanwhile.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      alu_mdu_pipe_if.slave (operands, forwarding, handshake,
//              Result/Zero/out_valid/busy)
//
//   ALUOp: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0011 XOR,
//          0100 SLL, 0101 SRL, 1101 SRA, 0111 SLT (signed),
//          1000 MUL, 1001 MULHU, 1010 DIVU, 1011 REMU,
//          anything else -> Result 0.
// -----------------------------------------------------------------------------
module alu_mdu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_mdu_pipe_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               out_valid_q;
  logic               busy_q;

  // Shared iteration register: MUL keeps {product_hi, multiplier/product_lo},
  // DIV keeps {remainder, dividend/quotient}. opnd_q is multiplicand/divisor.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   count_q;
  logic               hi_sel_q;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b_fwd;
  logic [WIDTH-1:0]   op_b;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               is_multi;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   fin_res;

  // ---------------------------------------------------------------------------
  // Operand forwarding (10 = EX/MEM, 01 = MEM/WB, 00/11 = register file)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    op_a     = bus.A;
    op_b_fwd = bus.B;
    unique case (bus.Forward_A)
      2'b10:   op_a = bus.EM_Result;
      2'b01:   op_a = bus.Out;
      default: op_a = bus.A;
    endcase
    unique case (bus.Forward_B)
      2'b10:   op_b_fwd = bus.EM_Result;
      2'b01:   op_b_fwd = bus.Out;
      default: op_b_fwd = bus.B;
    endcase
    op_b  = bus.ALUSrc ? bus.IDEX_Imm : op_b_fwd;
    shamt = op_b[SH_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU; undefined codes fall through to a zero result
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res  = '0;
    is_multi = 1'b0;
    case (bus.ALUOp)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: is_multi = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the multi-cycle units
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift-add: conditionally add multiplicand to the high half, then shift
    // the whole accumulator (with the add carry) right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and try a
    // subtract. The partial remainder is always < divisor, so the shifted
    // value fits WIDTH+1 bits and bit WIDTH of the difference is the borrow.
    // A zero divisor never borrows: quotient all ones, remainder = dividend.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

    step_next = (state_q == S_DIV) ? div_next : mul_next;

    // ALUOp[0] selects the high half in both units: MULHU -> product high,
    // REMU -> remainder; MUL/DIVU take the low half.
    fin_res = hi_sel_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the iteration registers are plain flops, not a memory array,
      // so they are reset together with the control state.
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      count_q     <= '0;
      hi_sel_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden later in the block, giving a single-cycle pulse.
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            if (is_multi) begin
              // ALUOp[1]: 1 = divide (dividend in acc), 0 = multiply
              acc_q    <= {{WIDTH{1'b0}}, (bus.ALUOp[1] ? op_a : op_b)};
              opnd_q   <= bus.ALUOp[1] ? op_b : op_a;
              count_q  <= CNT_W'(WIDTH);
              hi_sel_q <= bus.ALUOp[0];
              busy_q   <= 1'b1;
              state_q  <= bus.ALUOp[1] ? S_DIV : S_MUL;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q   <= step_next;
            count_q <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              result_q    <= fin_res;
              zero_q      <= (fin_res == '0);
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.in_ready  = ~busy_q;

endmodule

// File: tb/tb_alu_mdu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu_pipe
//   Directed bench for alu_mdu_pipe: a WIDTH=64 instance for forwarding,
//   single-cycle ops, multiply/divide latency, flush and mid-op reset, and a
//   WIDTH=32 instance for SRA, SLT, MUL latency and an undefined opcode.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_mdu_pipe;

  logic clk;
  logic reset_n;

  alu_mdu_pipe_if #(.WIDTH(64)) bus64 ();
  alu_mdu_pipe_if #(.WIDTH(32)) bus32 ();

  alu_mdu_pipe #(.WIDTH(64)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus64.slave)
  );

  alu_mdu_pipe #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op to the 64-bit instance for exactly one rising edge.
  task automatic issue64(input logic [3:0] op, input logic [1:0] fa,
                         input logic [1:0] fb, input logic src,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] em, input logic [63:0] wb,
                         input logic [63:0] imm);
    bus64.ALUOp     = op;
    bus64.Forward_A = fa;
    bus64.Forward_B = fb;
    bus64.ALUSrc    = src;
    bus64.A         = a;
    bus64.B         = b;
    bus64.EM_Result = em;
    bus64.Out       = wb;
    bus64.IDEX_Imm  = imm;
    bus64.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
  endtask

  task automatic sc64(input string tag, input logic [3:0] op,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp);
    issue64(op, 2'b00, 2'b00, 1'b0, a, b, '0, '0, '0);
    check({tag, "_ov"},  {63'd0, bus64.out_valid}, 64'd1);
    check({tag, "_res"}, bus64.Result, exp);
    check({tag, "_z"},   {63'd0, bus64.Zero}, {63'd0, (exp == 64'd0)});
  endtask

  task automatic mc64(input string tag, input logic [3:0] op,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp);
    int lat;
    logic stall_ok;
    issue64(op, 2'b00, 2'b00, 1'b0, a, b, '0, '0, '0);
    check({tag, "_busy0"}, {62'd0, bus64.busy, bus64.in_ready}, 64'b10);
    lat      = 0;
    stall_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus64.out_valid) break;
      if (!bus64.busy || bus64.in_ready) stall_ok = 1'b0;
    end
    check({tag, "_lat"},   64'(lat), 64'd64);
    check({tag, "_stall"}, {63'd0, stall_ok}, 64'd1);
    check({tag, "_idle"},  {62'd0, bus64.busy, bus64.in_ready}, 64'b01);
    check({tag, "_res"},   bus64.Result, exp);
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus32.ALUOp    = op;
    bus32.A        = a;
    bus32.B        = b;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic sc32(input string tag, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    issue32(op, a, b);
    check({tag, "_ov"},  {63'd0, bus32.out_valid}, 64'd1);
    check({tag, "_res"}, {32'd0, bus32.Result}, {32'd0, exp});
    check({tag, "_z"},   {63'd0, bus32.Zero}, {63'd0, (exp == 32'd0)});
  endtask

  // Watch for a stray out_valid over a window longer than any operation.
  task automatic no_pulse64(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus64.out_valid) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int lat32;

    reset_n         = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.flush     = 1'b0;
    bus64.ALUOp     = '0;
    bus64.A         = '0;
    bus64.B         = '0;
    bus64.Out       = '0;
    bus64.EM_Result = '0;
    bus64.Forward_A = '0;
    bus64.Forward_B = '0;
    bus64.ALUSrc    = 1'b0;
    bus64.IDEX_Imm  = '0;
    bus32.in_valid  = 1'b0;
    bus32.flush     = 1'b0;
    bus32.ALUOp     = '0;
    bus32.A         = '0;
    bus32.B         = '0;
    bus32.Out       = '0;
    bus32.EM_Result = '0;
    bus32.Forward_A = '0;
    bus32.Forward_B = '0;
    bus32.ALUSrc    = 1'b0;
    bus32.IDEX_Imm  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result",   bus64.Result, 64'd0);
    check("rst_zero",     {63'd0, bus64.Zero}, 64'd1);
    check("rst_ov",       {63'd0, bus64.out_valid}, 64'd0);
    check("rst_busy",     {63'd0, bus64.busy}, 64'd0);
    check("rst_in_ready", {63'd0, bus64.in_ready}, 64'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD 5 + 7, then the pulse drops and Result holds
    sc64("add", 4'b0010, 64'd5, 64'd7, 64'd12);
    @(posedge clk); #1;
    check("add_ov_drop", {63'd0, bus64.out_valid}, 64'd0);
    check("add_hold",    bus64.Result, 64'd12);

    // flush in IDLE suppresses acceptance
    bus64.flush = 1'b1;
    issue64(4'b0010, 2'b00, 2'b00, 1'b0, 64'd1, 64'd1, '0, '0, '0);
    bus64.flush = 1'b0;
    check("idle_flush_ov",  {63'd0, bus64.out_valid}, 64'd0);
    check("idle_flush_res", bus64.Result, 64'd12);

    // SUB with forwarding: A <- EM_Result, B <- Out
    issue64(4'b0110, 2'b10, 2'b01, 1'b0, 64'd3, 64'd4,
            64'h20, 64'h20, '0);
    check("sub_fwd_res", bus64.Result, 64'd0);
    check("sub_fwd_z",   {63'd0, bus64.Zero}, 64'd1);
    // Same, immediate replaces forwarded B: 0x20 - (-1) = 0x21
    issue64(4'b0110, 2'b10, 2'b01, 1'b1, 64'd3, 64'd4,
            64'h20, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sub_imm_res", bus64.Result, 64'h21);
    check("sub_imm_z",   {63'd0, bus64.Zero}, 64'd0);

    // Back-to-back single-cycle acceptance
    sc64("b2b_1", 4'b0010, 64'd1, 64'd2, 64'd3);
    sc64("b2b_2", 4'b0010, 64'd3, 64'd4, 64'd7);

    // Logic, shift, compare, wrap, undefined
    sc64("and", 4'b0000, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F,
         64'h00F0_0000_0000_000F);
    sc64("or",  4'b0001, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F,
         64'hFFF0_0000_0000_0FFF);
    sc64("xor", 4'b0011, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F,
         64'hFF00_0000_0000_0FF0);
    sc64("nor", 4'b1100, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F,
         64'h000F_FFFF_FFFF_F000);
    sc64("sll", 4'b0100, 64'h8000_0000_0000_0001, 64'h44,
         64'h0000_0000_0000_0010);
    sc64("srl", 4'b0101, 64'h8000_0000_0000_0001, 64'd4,
         64'h0800_0000_0000_0000);
    sc64("sra", 4'b1101, 64'h8000_0000_0000_0001, 64'd4,
         64'hF800_0000_0000_0000);
    sc64("slt_t", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    sc64("slt_f", 4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    sc64("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    sc64("b2b_pre", 4'b0010, 64'd9, 64'd9, 64'd18);
    sc64("undef", 4'b1110, 64'd9, 64'd9, 64'd0);

    // Multi-cycle: latency 64 in every case, including divide by zero
    mc64("mul",   4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
         64'hFFFF_FFFF_FFFF_FFFE);
    mc64("mulhu", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
    mc64("divu",  4'b1010, 64'd100, 64'd7, 64'd14);
    mc64("remu",  4'b1011, 64'd100, 64'd7, 64'd2);
    mc64("divu0", 4'b1010, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    mc64("remu0", 4'b1011, 64'd9, 64'd0, 64'd9);

    // flush mid-divide: back to IDLE next edge, Result keeps 9
    issue64(4'b1010, 2'b00, 2'b00, 1'b0, 64'd100, 64'd7, '0, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    bus64.flush = 1'b1;
    @(posedge clk); #1;
    bus64.flush = 1'b0;
    check("flush_state", {61'd0, bus64.busy, bus64.in_ready, bus64.out_valid},
          64'b010);
    check("flush_res",   bus64.Result, 64'd9);
    no_pulse64("flush_no_ov");

    // Reset mid-divide: immediate return to reset values
    issue64(4'b1010, 2'b00, 2'b00, 1'b0, 64'd100, 64'd7, '0, '0, '0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_res",  bus64.Result, 64'd0);
    check("mid_rst_z",    {63'd0, bus64.Zero}, 64'd1);
    check("mid_rst_busy", {63'd0, bus64.busy}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    no_pulse64("mid_rst_no_ov");

    // WIDTH=32 instance
    sc32("w32_sra", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000);
    sc32("w32_slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    sc32("w32_add", 4'b0010, 32'd1, 32'd2, 32'd3);
    sc32("w32_undef", 4'b1111, 32'd1, 32'd2, 32'd0);

    issue32(4'b1000, 32'hFFFF_FFFF, 32'd3);
    lat32 = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat32++;
      if (bus32.out_valid) break;
    end
    check("w32_mul_lat", 64'(lat32), 64'd32);
    check("w32_mul_res", {32'd0, bus32.Result}, 64'h0000_0000_FFFF_FFFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
